var_bw_mul_seq: RTL

VAR_BW_MUL_SEQ -- requirements
Module: var_bw_mul_seq

---
 rtl/var_bw_mul_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/var_bw_mul_seq.sv
// Sequential variable-bit-width unsigned multiplier: one W-bit lane, two W/2 lanes or
// four W/4 lanes, one shift-add step per cycle per lane, valid/ready on both sides.
module var_bw_mul_seq #(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   p
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [1:0]         mode_reg;
    logic [2*W-1:0]     acc_reg;
    logic [2*W-1:0]     p_reg;
    logic [CW-1:0]      cnt_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;

    // One candidate accumulator update per lane layout; the captured mode picks one.
    logic [2:0][2*W-1:0] step;
    logic [1:0]          step_sel;
    logic [CW-1:0]       last_cnt;
    logic [2*W-1:0]      step_next;

    genvar gm, gi;
    generate
        for (gm = 0; gm < 3; gm++) begin : g_mode
            localparam int L  = 1 << gm;
            localparam int LW = W / L;
            for (gi = 0; gi < L; gi++) begin : g_lane
                logic [LW-1:0]   a_lane;
                logic [2*LW-1:0] addend;
                assign a_lane = a_reg[gi*LW +: LW];
                assign addend = (((b_reg[gi*LW +: LW] >> cnt_reg) & LW'(1)) != '0)
                                ? ({{LW{1'b0}}, a_lane} << cnt_reg) : '0;
                assign step[gm][gi*2*LW +: 2*LW] = acc_reg[gi*2*LW +: 2*LW] + addend;
            end
        end
    endgenerate

    always_comb begin
        step_sel = 2'd0;
        last_cnt = CW'(W - 1);
        case (mode_reg)
            2'b01: begin
                step_sel = 2'd1;
                last_cnt = CW'(W / 2 - 1);
            end
            2'b10: begin
                step_sel = 2'd2;
                last_cnt = CW'(W / 4 - 1);
            end
            default: begin
                step_sel = 2'd0;
                last_cnt = CW'(W - 1);
            end
        endcase
        step_next = step[step_sel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            mode_reg      <= '0;
            acc_reg       <= '0;
            p_reg         <= '0;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= a;
                        b_reg        <= b;
                        mode_reg     <= mode;
                        acc_reg      <= '0;
                        cnt_reg      <= '0;
                        state        <= BUSY;
                        in_ready_reg <= 1'b0;
                    end
                end
                BUSY: begin
                    acc_reg <= step_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == last_cnt) begin
                        p_reg         <= step_next;
                        state         <= DONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state         <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign p         = p_reg;

endmodule
